rr_stream_multiplexer: RTL and testbench



---
 rtl/rr_stream_multiplexer_if.sv | 37 +++
 rtl/rr_stream_multiplexer.sv | 152 +++++++++++++++
 tb/tb_rr_stream_multiplexer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_multiplexer_if.sv
// Stream bundle for the round-robin multiplexer.
// Packet-lock signals exist only when MUX_PACKET_LOCK_EN is defined.
interface rr_stream_multiplexer_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
);
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_ready;
   logic                      out_valid;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_sel;
   logic                      out_ready;
`ifdef MUX_PACKET_LOCK_EN
   logic [CHANNELS-1:0]       in_last;
   logic                      out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_last
   );
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_last
   );
`else
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
`endif
endinterface

// File: rtl/rr_stream_multiplexer.sv
// Round-robin N:1 valid/ready stream mux with one registered output stage.
// Define MUX_PACKET_LOCK_EN to hold the grant until a packet's last beat.
module rr_stream_multiplexer #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   rr_stream_multiplexer_if.slave bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0]    ptr_q;
   logic [SEL_W-1:0]    grant;
   logic [SEL_W-1:0]    idx;
   logic                grant_vld;
   logic [CHANNELS-1:0] req;
   logic                load;
   logic                accept;
   logic                adv;

   logic                out_valid_q;
   logic [WIDTH-1:0]    out_data_q;
   logic [SEL_W-1:0]    out_sel_q;

   function automatic logic [SEL_W-1:0] wrap_inc(
      input logic [SEL_W-1:0] i
   );
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   assign load   = !out_valid_q || bus.out_ready;
   assign accept = grant_vld && load;

`ifdef MUX_PACKET_LOCK_EN
   typedef enum logic {
      S_OPEN,
      S_LOCKED
   } lock_t;

   lock_t            state_q;
   lock_t            state_d;
   logic [SEL_W-1:0] owner_q;
   logic [SEL_W-1:0] owner_d;
   logic             out_last_q;
   logic             grant_last;

   assign grant_last = bus.in_last[grant];

   // While locked only the owner may request; others stay invisible.
   always_comb begin
      req = bus.in_valid;
      if (state_q == S_LOCKED) begin
         req = bus.in_valid & (CHANNELS'(1) << owner_q);
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      unique case (state_q)
         S_OPEN: begin
            if (accept && !grant_last) begin
               state_d = S_LOCKED;
               owner_d = grant;
            end
         end
         S_LOCKED: begin
            if (accept && grant_last) begin
               state_d = S_OPEN;
            end
         end
         default: state_d = S_OPEN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OPEN;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   assign adv = accept && grant_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last_q <= 1'b0;
      end else if (accept) begin
         out_last_q <= grant_last;
      end
   end

   assign bus.out_last = out_last_q;
`else
   assign req = bus.in_valid;
   assign adv = accept;
`endif

   // Search ptr, ptr+1, ... wrapping modulo CHANNELS.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = ptr_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!grant_vld && req[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
         idx = wrap_inc(idx);
      end
   end

   // Gated by rst_n so ready reads low throughout reset.
   always_comb begin
      bus.in_ready = '0;
      if (rst_n && accept) begin
         bus.in_ready = CHANNELS'(1) << grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv) begin
         ptr_q <= wrap_inc(grant);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
         out_sel_q   <= grant;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_multiplexer.sv
// Directed bench for rr_stream_multiplexer (WIDTH=8, CHANNELS=4).
// Packet-lock steps run only when MUX_PACKET_LOCK_EN is defined.
module tb_rr_stream_multiplexer;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   rr_stream_multiplexer_if #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS)
   ) bus ();

   rr_stream_multiplexer #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [7:0] d);
      bus.in_data[c*WIDTH +: WIDTH] = d;
   endtask

   initial begin
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef MUX_PACKET_LOCK_EN
      bus.in_last   = '0;
`endif
      tick();
      tick();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_sel", bus.out_sel, 0);
      chk("rst_ready", bus.in_ready, 0);

      // single channel: ch2 sends A5
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid = 4'b0100;
      set_ch(2, 8'hA5);
      #1 chk("single_rdy", bus.in_ready, 4'b0100);
      tick();
      chk("single_valid", bus.out_valid, 1);
      chk("single_data", bus.out_data, 8'hA5);
      chk("single_sel", bus.out_sel, 2);
      bus.in_valid = '0;
      #1 chk("idle_rdy", bus.in_ready, 0);
      tick();
      chk("drain_valid", bus.out_valid, 0);
      chk("drain_hold", bus.out_data, 8'hA5);
      chk("drain_sel", bus.out_sel, 2);

      // wrap: ptr=3, ch1 and ch3 valid
      bus.in_valid = 4'b1010;
      set_ch(1, 8'h51);
      set_ch(3, 8'h53);
      #1 chk("wrap_rdy0", bus.in_ready, 4'b1000);
      tick();
      chk("wrap_sel0", bus.out_sel, 3);
      chk("wrap_data0", bus.out_data, 8'h53);
      #1 chk("wrap_rdy1", bus.in_ready, 4'b0010);
      tick();
      chk("wrap_sel1", bus.out_sel, 1);
      chk("wrap_data1", bus.out_data, 8'h51);

      // reset mid-stream with a held beat
      bus.in_valid = 4'b0001;
      set_ch(0, 8'h77);
      tick();
      chk("pre_rst_valid", bus.out_valid, 1);
      chk("pre_rst_data", bus.out_data, 8'h77);
      bus.out_ready = 1'b0;
      bus.in_valid = 4'b1111;
      for (int c = 0; c < 4; c++) set_ch(c, 8'(8'h10 + c));
      #1 chk("stall_rdy", bus.in_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid", bus.out_valid, 0);
      chk("async_data", bus.out_data, 0);
      chk("async_sel", bus.out_sel, 0);
      chk("async_rdy", bus.in_ready, 0);
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1 chk("post_rst_rdy", bus.in_ready, 4'b0001);

      // round robin over all four channels
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_valid", bus.out_valid, 1);
         chk("rr_sel", bus.out_sel, k % 4);
         chk("rr_data", bus.out_data, 8'h10 + (k % 4));
      end

      // backpressure for 3 cycles, then no-bubble reload
      bus.out_ready = 1'b0;
      #1 chk("bp_rdy", bus.in_ready, 0);
      repeat (3) begin
         tick();
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_sel", bus.out_sel, 0);
         chk("bp_data", bus.out_data, 8'h10);
         chk("bp_rdy_hold", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1 chk("bp_release_rdy", bus.in_ready, 4'b0010);
      tick();
      chk("bp_next_valid", bus.out_valid, 1);
      chk("bp_next_sel", bus.out_sel, 1);
      chk("bp_next_data", bus.out_data, 8'h11);
      bus.in_valid = '0;
      tick();
      chk("end_valid", bus.out_valid, 0);

`ifdef MUX_PACKET_LOCK_EN
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      chk("lk_rst_last", bus.out_last, 0);
      bus.in_valid = 4'b0001;
      bus.in_last  = 4'b0001;
      set_ch(0, 8'h0F);
      tick();
      chk("lk_pre_sel", bus.out_sel, 0);
      bus.in_valid = 4'b0011;
      set_ch(1, 8'h21);
      #1 chk("lk_rdy0", bus.in_ready, 4'b0010);
      tick();
      chk("lk_sel0", bus.out_sel, 1);
      chk("lk_data0", bus.out_data, 8'h21);
      chk("lk_last0", bus.out_last, 0);
      set_ch(1, 8'h22);
      #1 chk("lk_rdy1", bus.in_ready, 4'b0010);
      tick();
      chk("lk_sel1", bus.out_sel, 1);
      chk("lk_data1", bus.out_data, 8'h22);
      bus.in_valid = 4'b0001;
      #1 chk("lk_owner_idle", bus.in_ready, 0);
      tick();
      chk("lk_gap_valid", bus.out_valid, 0);
      bus.in_valid = 4'b0011;
      bus.in_last  = 4'b0011;
      set_ch(1, 8'h23);
      #1 chk("lk_rdy2", bus.in_ready, 4'b0010);
      tick();
      chk("lk_sel2", bus.out_sel, 1);
      chk("lk_data2", bus.out_data, 8'h23);
      chk("lk_last2", bus.out_last, 1);
      bus.in_valid = 4'b0001;
      #1 chk("lk_unlock_rdy", bus.in_ready, 4'b0001);
      tick();
      chk("lk_sel3", bus.out_sel, 0);
      chk("lk_data3", bus.out_data, 8'h0F);
      bus.in_valid = '0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
